// File: rtl/ir_decoder.sv
// NEC infrared frame decoder: turns receiver pulses into a 3-bit drive command.
// Repeat codes keep ir_ready asserted while the remote button is held.
module ir_decoder #(
  parameter int unsigned clk_hz    = 25000000,
  parameter logic [7:0]  ADDR      = 8'h00,
  parameter logic [7:0]  KEY_ON    = 8'h45,
  parameter logic [7:0]  KEY_OFF   = 8'h46,
  parameter logic [7:0]  KEY_FWD   = 8'h18,
  parameter logic [7:0]  KEY_BWD   = 8'h52,
  parameter logic [7:0]  KEY_LEFT  = 8'h08,
  parameter logic [7:0]  KEY_RIGHT = 8'h5A,
  parameter logic [7:0]  KEY_STOP  = 8'h1C,
  parameter int unsigned HOLD_US   = 110000,
  // Divides every pulse window; 1 gives real NEC timing.
  parameter int unsigned TIME_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ir_rx,
  output logic       ir_ready,
  output logic [2:0] command,
  output logic       frame_err
);

  localparam int unsigned TickDiv = (clk_hz / 1000000 > 1) ? clk_hz / 1000000 : 1;
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned HoldW   = $clog2(HOLD_US + 1);

  localparam logic [13:0] LeadMarkMin = 14'(8000 / TIME_DIV);
  localparam logic [13:0] LeadMarkMax = 14'(10000 / TIME_DIV);
  localparam logic [13:0] LeadDataMin = 14'(4000 / TIME_DIV);
  localparam logic [13:0] LeadDataMax = 14'(5000 / TIME_DIV);
  localparam logic [13:0] LeadRepMin  = 14'(1800 / TIME_DIV);
  localparam logic [13:0] LeadRepMax  = 14'(2700 / TIME_DIV);
  localparam logic [13:0] ShortMin    = 14'(400 / TIME_DIV);
  localparam logic [13:0] ShortMax    = 14'(750 / TIME_DIV);
  localparam logic [13:0] LongMin     = 14'(1400 / TIME_DIV);
  localparam logic [13:0] LongMax     = 14'(1900 / TIME_DIV);

  typedef enum logic [2:0] {
    StIdle, StLeadMark, StLeadSpace, StBitMark, StBitSpace, StStopMark, StRepMark
  } state_e;

  state_e           state_q, state_d;
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic             fall, rise;
  logic [PreW-1:0]  pre_q;
  logic             tick;
  logic [13:0]      dur_q;
  logic [31:0]      sr_q, sr_d;
  logic [5:0]       bitcnt_q, bitcnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             ready_q, err_q, abort;
  logic [7:0]       f_addr, f_naddr, f_cmd, f_ncmd;
  logic             key_hit, frame_ok;
  logic [2:0]       key_code;

  function automatic logic in_win(input logic [13:0] v, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= ir_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s2_q;
  assign rise = ~rx_prev_q & rx_s2_q;
  assign tick = (pre_q == PreW'(TickDiv - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      dur_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (fall || rise) begin
        dur_q <= '0;
      end else if (tick && dur_q != 14'h3FFF) begin
        dur_q <= dur_q + 14'd1;
      end
    end
  end

  assign {f_ncmd, f_cmd, f_naddr, f_addr} = sr_q;

  always_comb begin
    key_hit  = 1'b1;
    key_code = 3'b111;
    if      (f_cmd == KEY_ON)    key_code = 3'd0;
    else if (f_cmd == KEY_OFF)   key_code = 3'd1;
    else if (f_cmd == KEY_FWD)   key_code = 3'd2;
    else if (f_cmd == KEY_BWD)   key_code = 3'd3;
    else if (f_cmd == KEY_LEFT)  key_code = 3'd4;
    else if (f_cmd == KEY_RIGHT) key_code = 3'd5;
    else if (f_cmd == KEY_STOP)  key_code = 3'd6;
    else                         key_hit  = 1'b0;
  end

  assign frame_ok = (f_addr == ADDR) && (f_naddr == ~f_addr) && (f_cmd == ~f_ncmd) && key_hit;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    cmd_d    = cmd_q;
    hold_d   = (tick && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    abort    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall) state_d = StLeadMark;
      end
      StLeadMark: begin
        if (dur_q > LeadMarkMax) abort = 1'b1;
        else if (rise) begin
          if (in_win(dur_q, LeadMarkMin, LeadMarkMax)) state_d = StLeadSpace;
          else abort = 1'b1;
        end
      end
      StLeadSpace: begin
        if (dur_q > LeadDataMax) abort = 1'b1;
        else if (fall) begin
          if (in_win(dur_q, LeadDataMin, LeadDataMax)) begin
            state_d  = StBitMark;
            bitcnt_d = '0;
            sr_d     = '0;
          end else if (in_win(dur_q, LeadRepMin, LeadRepMax)) begin
            state_d = StRepMark;
          end else begin
            abort = 1'b1;
          end
        end
      end
      StBitMark: begin
        if (dur_q > ShortMax) abort = 1'b1;
        else if (rise) begin
          if (in_win(dur_q, ShortMin, ShortMax)) state_d = StBitSpace;
          else abort = 1'b1;
        end
      end
      StBitSpace: begin
        if (dur_q > LongMax) abort = 1'b1;
        else if (fall) begin
          if (in_win(dur_q, ShortMin, ShortMax) || in_win(dur_q, LongMin, LongMax)) begin
            // LSB-first: the first bit received ends up in sr_q[0].
            sr_d     = {in_win(dur_q, LongMin, LongMax), sr_q[31:1]};
            bitcnt_d = bitcnt_q + 6'd1;
            state_d  = (bitcnt_q == 6'd31) ? StStopMark : StBitMark;
          end else begin
            abort = 1'b1;
          end
        end
      end
      StStopMark: begin
        if (dur_q > ShortMax) abort = 1'b1;
        else if (rise) begin
          if (in_win(dur_q, ShortMin, ShortMax) && frame_ok) begin
            state_d = StIdle;
            cmd_d   = key_code;
            hold_d  = HoldW'(HOLD_US);
          end else begin
            abort = 1'b1;
          end
        end
      end
      StRepMark: begin
        if (dur_q > ShortMax) abort = 1'b1;
        else if (rise) begin
          // A repeat only extends a command that is still being held.
          if (in_win(dur_q, ShortMin, ShortMax) && hold_q != '0) begin
            state_d = StIdle;
            hold_d  = HoldW'(HOLD_US);
          end else begin
            abort = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bitcnt_q <= '0;
      hold_q   <= '0;
      cmd_q    <= 3'b111;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      hold_q   <= hold_d;
      cmd_q    <= cmd_d;
      ready_q  <= (hold_d != '0);
      err_q    <= abort;
    end
  end

  assign ir_ready  = ready_q;
  assign command   = cmd_q;
  assign frame_err = err_q;

endmodule
